// File: rtl/timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// timer_run_ctrl
// Run/pause/clear sequencer and 1 Hz tick generator for the minute:second
// timer path. Owns the clock prescaler and counts seconds/minutes up to a
// minute limit that is latched when a run starts.
//
// Optional feature macro: TIMER_AUTORELOAD_EN
//   defined   - a completed run restarts from 0:00 without leaving RUN,
//               done pulses for one cycle, and reload_cnt counts
//               completions (saturating at 255).
//   undefined - a completed run parks in DONE with done held high until
//               clear or reset; reload_cnt does not exist.
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      synchronous reset, active-low
//   start      in   1      level command: begin or resume counting
//   stop       in   1      level command: pause counting
//   clear      in   1      level command: abort to idle, counters zeroed
//   limit_min  in   MIN_W  run length in minutes, sampled on IDLE->RUN only
//   sec_tick   out  1      one-cycle pulse per counted second
//   sec_cnt    out  6      seconds 0..59
//   min_cnt    out  MIN_W  completed minutes
//   running    out  1      state is RUN
//   paused     out  1      state is PAUSE
//   done       out  1      completion flag
//   reload_cnt out  8      completions so far (TIMER_AUTORELOAD_EN only)
// -----------------------------------------------------------------------------
module timer_run_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 32'd125000000,
    parameter int unsigned MIN_W         = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [MIN_W-1:0] limit_min,
    output logic             sec_tick,
    output logic [5:0]       sec_cnt,
    output logic [MIN_W-1:0] min_cnt,
    output logic             running,
    output logic             paused,
    output logic             done
`ifdef TIMER_AUTORELOAD_EN
    ,
    output logic [7:0]       reload_cnt
`endif
);

    localparam int unsigned   PW         = (TICKS_PER_SEC > 32'd2) ? $clog2(TICKS_PER_SEC) : 32'd1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [PW-1:0]    presc_q,    presc_d;
    logic             sec_tick_q, sec_tick_d;
    logic [5:0]       sec_q,      sec_d;
    logic [MIN_W-1:0] min_q,      min_d;
    logic [MIN_W-1:0] limit_q,    limit_d;
    logic             done_q,     done_d;
    logic [MIN_W-1:0] min_inc;
`ifdef TIMER_AUTORELOAD_EN
    logic [7:0]       reload_q,   reload_d;
`endif

    assign min_inc = min_q + MIN_W'(1);

    // Next-state, prescaler and counter update; clear outranks stop outranks start.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_tick_d = 1'b0;
        sec_d      = sec_q;
        min_d      = min_q;
        limit_d    = limit_q;
`ifdef TIMER_AUTORELOAD_EN
        done_d     = 1'b0;
        reload_d   = reload_q;
`else
        done_d     = done_q;
`endif
        if (clear) begin
            state_d  = ST_IDLE;
            presc_d  = '0;
            sec_d    = 6'd0;
            min_d    = '0;
            done_d   = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_d = 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero limit would complete instantly, so it never starts a run.
                    if (start && !stop && (limit_min != '0)) begin
                        state_d = ST_RUN;
                        limit_d = limit_min;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // stop freezes the prescaler, even on its terminal count.
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d    = '0;
                        sec_tick_d = 1'b1;
                        if (sec_q == 6'd59) begin
                            sec_d = 6'd0;
                            min_d = min_inc;
                            if (min_inc == limit_q) begin
                                done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                                min_d    = '0;
                                reload_d = (reload_q == 8'hFF) ? reload_q : reload_q + 8'd1;
`else
                                state_d  = ST_DONE;
`endif
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            sec_q      <= 6'd0;
            min_q      <= '0;
            limit_q    <= '0;
            done_q     <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            reload_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            limit_q    <= limit_d;
            done_q     <= done_d;
`ifdef TIMER_AUTORELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign sec_tick = sec_tick_q;
    assign sec_cnt  = sec_q;
    assign min_cnt  = min_q;
    assign running  = (state_q == ST_RUN);
    assign paused   = (state_q == ST_PAUSE);
    assign done     = done_q;
`ifdef TIMER_AUTORELOAD_EN
    assign reload_cnt = reload_q;
`endif

endmodule

// File: tb/tb_timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_run_ctrl
// Directed bench for timer_run_ctrl (TICKS_PER_SEC=4, MIN_W=4). A reference
// model tracks total counted RUN cycles since the last clear/reset and derives
// seconds, minutes and ticks from that count arithmetically; it is compared
// with the DUT every cycle. Hand-computed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_timer_run_ctrl;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] limit_min = 4'd0;
    logic       sec_tick;
    logic [5:0] sec_cnt;
    logic [3:0] min_cnt;
    logic       running;
    logic       paused;
    logic       done;
`ifdef TIMER_AUTORELOAD_EN
    logic [7:0] reload_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    timer_run_ctrl #(.TICKS_PER_SEC(T), .MIN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .limit_min (limit_min),
        .sec_tick  (sec_tick),
        .sec_cnt   (sec_cnt),
        .min_cnt   (min_cnt),
        .running   (running),
        .paused    (paused),
        .done      (done)
`ifdef TIMER_AUTORELOAD_EN
        ,
        .reload_cnt(reload_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0=idle 1=run 2=pause 3=done; m_elapsed = counted RUN cycles.
    int m_state   = 0;
    int m_elapsed = 0;
    int m_limit   = 0;
    int m_reloads = 0;
    bit m_tick    = 1'b0;
    bit m_done    = 1'b0;

    // Model update at each posedge, comparison at the following negedge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_state = 0; m_elapsed = 0; m_limit = 0;
                m_reloads = 0; m_tick = 1'b0; m_done = 1'b0;
            end else if (clear) begin
                m_state = 0; m_elapsed = 0; m_reloads = 0;
                m_tick = 1'b0; m_done = 1'b0;
            end else begin
                m_tick = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
                m_done = 1'b0;
`endif
                case (m_state)
                    0: if (start && !stop && limit_min != 4'd0) begin
                        m_state = 1;
                        m_limit = int'(limit_min);
                    end
                    1: if (stop) begin
                        m_state = 2;
                    end else begin
                        m_elapsed++;
                        m_tick = ((m_elapsed % T) == 0);
                        if (m_elapsed == m_limit * 60 * T) begin
                            m_done = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                            m_elapsed = 0;
                            if (m_reloads < 255) m_reloads++;
`else
                            m_state = 3;
`endif
                        end
                    end
                    2: if (start && !stop) m_state = 1;
                    default: ;
                endcase
            end
            @(negedge clk);
            chk("cmp_sec_tick", 32'(sec_tick), 32'(m_tick));
            chk("cmp_sec_cnt",  32'(sec_cnt),  32'((m_elapsed / T) % 60));
            chk("cmp_min_cnt",  32'(min_cnt),  32'(m_elapsed / (T * 60)));
            chk("cmp_running",  32'(running),  32'(m_state == 1));
            chk("cmp_paused",   32'(paused),   32'(m_state == 2));
            chk("cmp_done",     32'(done),     32'(m_done));
`ifdef TIMER_AUTORELOAD_EN
            chk("cmp_reload",   32'(reload_cnt), 32'(m_reloads));
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1. reset, then a 2-minute run to completion
        step(2);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_sec", 32'(sec_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b1; limit_min = 4'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t1_running", 32'(running), 32'd1);
        step(3);
        chk("t1_no_tick_yet", 32'(sec_tick), 32'd0);
        step(1);
        chk("t1_first_tick", 32'(sec_tick), 32'd1);
        chk("t1_sec1", 32'(sec_cnt), 32'd1);
        step(1);
        chk("t1_tick_pulse", 32'(sec_tick), 32'd0);
        step(235);
        chk("t1_min1", 32'(min_cnt), 32'd1);
        chk("t1_min1_sec", 32'(sec_cnt), 32'd0);
        step(240);
`ifdef TIMER_AUTORELOAD_EN
        chk("t1_min_end", 32'(min_cnt), 32'd0);
        chk("t1_run_end", 32'(running), 32'd1);
`else
        chk("t1_min_end", 32'(min_cnt), 32'd2);
        chk("t1_run_end", 32'(running), 32'd0);
`endif
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_sec_end", 32'(sec_cnt), 32'd0);
        start = 1'b1;
        step(3);
        start = 1'b0;
`ifndef TIMER_AUTORELOAD_EN
        chk("t1_done_hold", 32'(done), 32'd1);
        chk("t1_done_norun", 32'(running), 32'd0);
`endif

        // 2. pause at sec 5 / presc 2, resume
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t2_clr_done", 32'(done), 32'd0);
        chk("t2_clr_min", 32'(min_cnt), 32'd0);
        limit_min = 4'd3; start = 1'b1;
        step(1);
        start = 1'b0;
        step(22);
        chk("t2_sec5", 32'(sec_cnt), 32'd5);
        stop = 1'b1;
        step(10);
        chk("t2_paused", 32'(paused), 32'd1);
        chk("t2_frozen", 32'(sec_cnt), 32'd5);
        stop = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t2_resumed", 32'(running), 32'd1);
        step(1);
        chk("t2_no_tick", 32'(sec_tick), 32'd0);
        step(1);
        chk("t2_tick", 32'(sec_tick), 32'd1);
        chk("t2_sec6", 32'(sec_cnt), 32'd6);

        // 3. stop on the terminal prescaler cycle
        step(3);
        stop = 1'b1;
        step(1);
        chk("t3_no_tick", 32'(sec_tick), 32'd0);
        chk("t3_paused", 32'(paused), 32'd1);
        chk("t3_sec_held", 32'(sec_cnt), 32'd6);
        step(1);
        stop = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t3_resume_no_tick", 32'(sec_tick), 32'd0);
        step(1);
        chk("t3_tick_first", 32'(sec_tick), 32'd1);
        chk("t3_sec7", 32'(sec_cnt), 32'd7);

        // 4. clear mid-run, start&stop in idle, zero limit, clear in DONE
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_clr_run", 32'(running), 32'd0);
        chk("t4_clr_sec", 32'(sec_cnt), 32'd0);
        start = 1'b1; stop = 1'b1;
        step(1);
        chk("t4_startstop", 32'(running), 32'd0);
        stop = 1'b0; limit_min = 4'd0;
        step(1);
        chk("t4_zero_limit", 32'(running), 32'd0);
        limit_min = 4'd1;
        step(1);
        start = 1'b0;
        step(240);
        chk("t4_done", 32'(done), 32'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
        chk("t4_stop_after", 32'(paused), 32'd1);
`else
        chk("t4_stop_after", 32'(paused), 32'd0);
        chk("t4_done_kept", 32'(done), 32'd1);
`endif
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_clr_done", 32'(done), 32'd0);
        chk("t4_clr_min", 32'(min_cnt), 32'd0);

        // 5. reset in RUN and in PAUSE, then a new limit is latched
        limit_min = 4'd2; start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("t5_rst_run", 32'(running), 32'd0);
        chk("t5_rst_sec", 32'(sec_cnt), 32'd0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        stop = 1'b1;
        step(1);
        chk("t5_paused", 32'(paused), 32'd1);
        rst = 1'b0;
        step(1);
        rst = 1'b1; stop = 1'b0;
        chk("t5_rst_pause", 32'(paused), 32'd0);
        chk("t5_rst_sec2", 32'(sec_cnt), 32'd0);
        limit_min = 4'd3; start = 1'b1;
        step(1);
        start = 1'b0; limit_min = 4'd1;
        step(240);
        chk("t5_min1", 32'(min_cnt), 32'd1);
        chk("t5_still_run", 32'(running), 32'd1);
        chk("t5_not_done", 32'(done), 32'd0);

`ifdef TIMER_AUTORELOAD_EN
        // 6. auto-reload, limit 1 minute
        clear = 1'b1;
        step(1);
        clear = 1'b0; limit_min = 4'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(719);
        chk("t6_reload2", 32'(reload_cnt), 32'd2);
        step(1);
        chk("t6_reload3", 32'(reload_cnt), 32'd3);
        chk("t6_done_pulse", 32'(done), 32'd1);
        chk("t6_running", 32'(running), 32'd1);
        step(1);
        chk("t6_done_low", 32'(done), 32'd0);
`endif

        step(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
